uart_rx: RTL and testbench

Serial receiver paired with the crypto accelerator's UART transmitter. It recovers 5–8-bit frames from the `Rx_in` line using a 16× oversampling `Tick` enable: one start bit, data bits LSB first, and one stop bit. Each received word is presented in a hold register with a valid/acknowledge handshake, so the host-side datapath can pull plaintext or key bytes at its own pace. Framing and overrun errors are flagged alongside each word.

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver with hold register and valid/ack handshake
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int OVERSAMPLE   = 16,
    parameter int SAMPLE_POINT = 7
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Rx_in,
    input  logic [3:0] N_bits,
    input  logic       Rd_ack,
    output logic [7:0] Message_out,
    output logic       Rx_valid,
    output logic       Rx_done,
    output logic       Frame_err,
    output logic       Overrun,
    output logic       Parity_err
);

    localparam logic [3:0] TLAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TMID  = 4'(SAMPLE_POINT);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t     state, state_nxt;
    logic       rx_m, rx_s;
    logic       armed;
    logic [3:0] tcnt, bcnt, nlat;
    logic [7:0] shreg;
    logic [7:0] word;
    logic [3:0] n_clamp;
    logic       start_ok, sample_bit, frame_done, last_bit;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= Rx_in;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    assign last_bit = (bcnt == nlat - 4'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (Tick && armed && !rx_s) state_nxt = START;
            START:  if (Tick && tcnt == TMID) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (Tick && tcnt == TLAST && last_bit) state_nxt = PARITY;
            PARITY: if (Tick && tcnt == TLAST) state_nxt = STOP;
`else
            DATA:   if (Tick && tcnt == TLAST && last_bit) state_nxt = STOP;
`endif
            STOP:   if (Tick && tcnt == TLAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ok   = (state == START) && Tick && (tcnt == TMID) && !rx_s;
        sample_bit = (state == DATA) && Tick && (tcnt == TLAST);
        frame_done = (state == STOP) && Tick && (tcnt == TLAST);
    end

    always_comb begin
        n_clamp = N_bits;
        if (N_bits < 4'd5) n_clamp = 4'd5;
        else if (N_bits > 4'd8) n_clamp = 4'd8;
    end

    // Bits shift in from the top, so the received word ends up in the upper nlat bits
    assign word = shreg >> (4'd8 - nlat);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            armed <= 1'b0;
            tcnt  <= 4'd0;
            bcnt  <= 4'd0;
            nlat  <= 4'd8;
            shreg <= 8'd0;
        end else begin
            if (state != IDLE)
                armed <= 1'b0;
            else if (Tick && rx_s)
                armed <= 1'b1;
            if (Tick) begin
                if (state == IDLE || start_ok) tcnt <= 4'd0;
                else                           tcnt <= tcnt + 4'd1;
            end
            if (start_ok) begin
                bcnt <= 4'd0;
                nlat <= n_clamp;
            end else if (sample_bit) begin
                bcnt <= bcnt + 4'd1;
            end
            if (sample_bit)
                shreg <= {rx_s, shreg[7:1]};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Message_out <= 8'd0;
            Rx_valid    <= 1'b0;
            Rx_done     <= 1'b0;
            Frame_err   <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            Rx_done <= frame_done;
            if (frame_done) begin
                Message_out <= word;
                Rx_valid    <= 1'b1;
                Frame_err   <= ~rx_s;
                // An ack on the completion cycle consumes the old word, so the new one is not an overrun
                if (Rx_valid) Overrun <= ~Rd_ack;
            end else if (Rd_ack && Rx_valid) begin
                Rx_valid <= 1'b0;
                Overrun  <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            par_bit    <= 1'b0;
            Parity_err <= 1'b0;
        end else begin
            if (state == PARITY && Tick && tcnt == TLAST)
                par_bit <= rx_s;
            if (frame_done)
                Parity_err <= (^word) ^ par_bit;
        end
    end
`else
    assign Parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx; Tick every 4 clocks, bit = 64 clocks
module tb_uart_rx;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Tick = 1'b0;
    logic       Rx_in = 1'b1;
    logic [3:0] N_bits = 4'd8;
    logic       Rd_ack = 1'b0;
    logic [7:0] Message_out;
    logic       Rx_valid, Rx_done, Frame_err, Overrun, Parity_err;

    typedef struct {
        logic [7:0] msg;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   sent = 0;

    uart_rx dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .Rx_in(Rx_in), .N_bits(N_bits),
        .Rd_ack(Rd_ack), .Message_out(Message_out), .Rx_valid(Rx_valid), .Rx_done(Rx_done),
        .Frame_err(Frame_err), .Overrun(Overrun), .Parity_err(Parity_err)
    );

    always #5 Clock = ~Clock;

    initial begin
        forever begin
            repeat (3) @(posedge Clock);
            #1 Tick = 1'b1;
            @(posedge Clock);
            #1 Tick = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always begin
        exp_t e;
        @(negedge Clock);
        if (Rx_done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rx_done", 32'(done_count), 32'(sent));
            end else begin
                e = exp_q.pop_front();
                chk("message_out", 32'(Message_out), 32'(e.msg));
                chk("frame_err", 32'(Frame_err), 32'(e.ferr));
                chk("parity_err", 32'(Parity_err), 32'(e.perr));
                chk("rx_valid_on_done", 32'(Rx_valid), 32'(1));
            end
            @(negedge Clock);
            chk("rx_done_one_cycle", 32'(Rx_done), 32'(0));
        end
    end

    task automatic line_bit(input logic b);
        Rx_in = b;
        repeat (64) @(posedge Clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [3:0] nf, input logic stop,
                              input logic pflip, input int idle_bits);
        int         n;
        logic [7:0] m;
        exp_t       e;
        n = (nf < 5) ? 5 : (nf > 8) ? 8 : int'(nf);
        m = 8'd0;
        for (int i = 0; i < n; i++) m[i] = data[i];
        e.msg  = m;
        e.ferr = ~stop;
`ifdef UART_RX_PARITY_EN
        e.perr = pflip;
`else
        e.perr = 1'b0;
`endif
        exp_q.push_back(e);
        sent++;
        N_bits = nf;
        line_bit(1'b0);
        for (int i = 0; i < n; i++) line_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        line_bit((^m) ^ pflip);
`endif
        line_bit(stop);
        for (int i = 0; i < idle_bits; i++) line_bit(1'b1);
    endtask

    task automatic ack();
        @(posedge Clock);
        #1 Rd_ack = 1'b1;
        @(posedge Clock);
        #1 Rd_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_message_out"}, 32'(Message_out), 32'(0));
        chk({tag, "_rx_valid"}, 32'(Rx_valid), 32'(0));
        chk({tag, "_rx_done"}, 32'(Rx_done), 32'(0));
        chk({tag, "_frame_err"}, 32'(Frame_err), 32'(0));
        chk({tag, "_overrun"}, 32'(Overrun), 32'(0));
        chk({tag, "_parity_err"}, 32'(Parity_err), 32'(0));
    endtask

    initial begin
        int d0;
        repeat (4) @(posedge Clock);
        #1;
        chk_all_zero("reset");
        Reset = 1'b1;
        repeat (70) @(posedge Clock);
        #1;

        send_frame(8'hA5, 4'd8, 1'b1, 1'b0, 1);
        chk("a5_rx_valid", 32'(Rx_valid), 32'(1));
        chk("a5_frame_err", 32'(Frame_err), 32'(0));
        ack();
        #1 chk("a5_ack_clears_valid", 32'(Rx_valid), 32'(0));
        ack();
        #1 chk("ack_when_empty_ignored", 32'(Rx_valid), 32'(0));

        send_frame(8'h13, 4'd5, 1'b1, 1'b0, 1);
        ack();
        send_frame(8'hFF, 4'd5, 1'b1, 1'b0, 1);
        chk("ff_n5_message", 32'(Message_out), 32'(8'h1F));

        // Abort a frame mid-DATA while a word is still unread
        N_bits = 4'd8;
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        repeat (20) @(posedge Clock);
        #1 Reset = 1'b0;
        Rx_in = 1'b1;
        repeat (3) @(posedge Clock);
        #1 chk_all_zero("midframe_reset");
        Reset = 1'b1;
        repeat (140) @(posedge Clock);
        #1;
        send_frame(8'h5A, 4'd8, 1'b1, 1'b0, 1);
        chk("5a_after_reset", 32'(Message_out), 32'(8'h5A));
        ack();

        send_frame(8'h66, 4'd8, 1'b0, 1'b0, 1);
        chk("stop0_frame_err", 32'(Frame_err), 32'(1));
        chk("stop0_word_valid", 32'(Rx_valid), 32'(1));
        ack();

        d0 = done_count;
        Rx_in = 1'b0;
        repeat (16) @(posedge Clock);
        #1 Rx_in = 1'b1;
        repeat (800) @(posedge Clock);
        #1 chk("glitch_no_done", 32'(done_count), 32'(d0));

        send_frame(8'h15, 4'd2, 1'b1, 1'b0, 1);
        ack();
        send_frame(8'h3C, 4'd12, 1'b1, 1'b0, 1);
        ack();

        send_frame(8'h11, 4'd8, 1'b1, 1'b0, 0);
        send_frame(8'h22, 4'd8, 1'b1, 1'b0, 1);
        chk("b2b_message", 32'(Message_out), 32'(8'h22));
        chk("b2b_overrun", 32'(Overrun), 32'(1));
        ack();
        #1;
        chk("b2b_ack_valid", 32'(Rx_valid), 32'(0));
        chk("b2b_ack_overrun", 32'(Overrun), 32'(0));

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 4'd8, 1'b1, 1'b1, 1);
        chk("parity_bad", 32'(Parity_err), 32'(1));
        ack();
        send_frame(8'h03, 4'd8, 1'b1, 1'b0, 1);
        chk("parity_good", 32'(Parity_err), 32'(0));
        ack();
`endif

        repeat (100) @(posedge Clock);
        #1;
        chk("all_frames_done", 32'(done_count), 32'(sent));
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        checks++;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
